// File: rtl/conv_pkg.sv
// Shared definitions for the convolution output stages: widths, FSM encoding,
// saturation bounds and the relu/shift/saturate requantizer.
package conv_pkg;

  localparam int DATA_W = 16;
  localparam int ACC_W  = 2 * DATA_W;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_FLUSH = 2'd2,
    ST_DONE  = 2'd3
  } acc_state_t;

  // Bounds kept at accumulator width so the clamp compares without resizing.
  localparam logic signed [ACC_W-1:0] SAT_MAX = ACC_W'((2 ** (DATA_W - 1)) - 1);
  localparam logic signed [ACC_W-1:0] SAT_MIN = ~SAT_MAX;

  function automatic logic signed [DATA_W-1:0] requant(
    input logic signed [ACC_W-1:0] sum,
    input logic                    relu,
    input logic [4:0]              shift
  );
    logic signed [ACC_W-1:0] v;
    v = (relu && sum[ACC_W-1]) ? '0 : sum;
    v = v >>> shift;
    if (v > SAT_MAX) begin
      return SAT_MAX[DATA_W-1:0];
    end else if (v < SAT_MIN) begin
      return SAT_MIN[DATA_W-1:0];
    end else begin
      return v[DATA_W-1:0];
    end
  endfunction

endpackage

// File: rtl/sync_fifo.sv
// Small synchronous FIFO with a show-ahead head and registered full/empty.
// A pop frees a slot for a same-cycle push even when full.
module sync_fifo #(
  parameter int WIDTH = 16,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] head,
  output logic             full,
  output logic             empty
);

  localparam int PTR_W = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr_reg, rd_ptr_reg;
  logic [PTR_W:0]   count_reg, count_next;
  logic             full_reg, empty_reg;
  logic             do_push, do_pop;

  assign do_pop  = pop && !empty_reg;
  assign do_push = push && (!full_reg || do_pop);

  always_comb begin
    count_next = count_reg;
    if (do_push && !do_pop) begin
      count_next = count_reg + 1'b1;
    end else if (do_pop && !do_push) begin
      count_next = count_reg - 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
      full_reg   <= 1'b0;
      empty_reg  <= 1'b1;
    end else begin
      if (do_push) wr_ptr_reg <= wr_ptr_reg + 1'b1;
      if (do_pop)  rd_ptr_reg <= rd_ptr_reg + 1'b1;
      count_reg <= count_next;
      full_reg  <= (count_next == (PTR_W+1)'(DEPTH));
      empty_reg <= (count_next == '0);
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr_reg] <= push_data;
  end

  // Head is forced to zero when empty so stale storage never shows after reset.
  assign head  = empty_reg ? '0 : mem[rd_ptr_reg];
  assign full  = full_reg;
  assign empty = empty_reg;

endmodule

// File: rtl/ofmap_accumulator.sv
// Accumulates partial sums across input-channel passes into an ofmap buffer and
// requantizes the final pass into an output FIFO.
module ofmap_accumulator
  import conv_pkg::*;
#(
  parameter int DATA_WIDTH  = DATA_W,
  parameter int ACC_WIDTH   = ACC_W,
  parameter int BUFFER_SIZE = 512,
  parameter int FIFO_DEPTH  = 4
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           cfg_start,
  input  logic [$clog2(BUFFER_SIZE):0]   cfg_num_pix,
  input  logic [7:0]                     cfg_num_pass,
  input  logic [4:0]                     cfg_shift,
  input  logic                           cfg_relu,
  input  logic                           psum_valid,
  input  logic signed [ACC_WIDTH-1:0]    psum_data,
  output logic                           psum_ready,
  output logic                           out_valid,
  output logic signed [DATA_WIDTH-1:0]   out_data,
  input  logic                           out_ready,
  output logic                           busy,
  output logic                           done,
  output logic                           err_cfg
);

  localparam int ADDR_W = $clog2(BUFFER_SIZE);
  localparam int PIX_W  = ADDR_W + 1;

  acc_state_t              state_reg;
  logic [PIX_W-1:0]        pix_reg, num_pix_reg;
  logic [7:0]              pass_reg, num_pass_reg;
  logic [4:0]              shift_reg;
  logic                    relu_reg;
  logic                    err_cfg_reg;

  logic signed [ACC_WIDTH-1:0] acc_mem [BUFFER_SIZE];
  logic signed [ACC_WIDTH-1:0] acc_rd, sum;
  logic [ADDR_W-1:0]           addr;

  logic                    fifo_full, fifo_empty;
  logic                    last_pix, last_pass, accept, push, cfg_legal;
  logic [DATA_WIDTH-1:0]   push_data, fifo_head;

  assign addr      = pix_reg[ADDR_W-1:0];
  assign acc_rd    = acc_mem[addr];
  assign last_pix  = (pix_reg == num_pix_reg - 1'b1);
  assign last_pass = (pass_reg == num_pass_reg - 8'd1);

  assign psum_ready = (state_reg == ST_RUN) && (!last_pass || !fifo_full);
  assign accept     = psum_valid && psum_ready;

  // Pass 0 ignores the stale buffer, which also covers single-pass jobs.
  assign sum       = (pass_reg == 8'd0) ? psum_data : acc_rd + psum_data;
  assign push      = accept && last_pass;
  assign push_data = requant(sum, relu_reg, shift_reg);

  assign cfg_legal = (cfg_num_pix != '0) &&
                     (cfg_num_pix <= PIX_W'(BUFFER_SIZE)) &&
                     (cfg_num_pass != 8'd0);

  always_ff @(posedge clk) begin
    if (accept) acc_mem[addr] <= sum;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg    <= ST_IDLE;
      pix_reg      <= '0;
      pass_reg     <= '0;
      num_pix_reg  <= '0;
      num_pass_reg <= '0;
      shift_reg    <= '0;
      relu_reg     <= 1'b0;
      err_cfg_reg  <= 1'b0;
    end else begin
      err_cfg_reg <= 1'b0;
      case (state_reg)
        ST_IDLE: begin
          if (cfg_start) begin
            if (cfg_legal) begin
              num_pix_reg  <= cfg_num_pix;
              num_pass_reg <= cfg_num_pass;
              shift_reg    <= cfg_shift;
              relu_reg     <= cfg_relu;
              pix_reg      <= '0;
              pass_reg     <= '0;
              state_reg    <= ST_RUN;
            end else begin
              err_cfg_reg <= 1'b1;
            end
          end
        end
        ST_RUN: begin
          if (accept) begin
            if (last_pix) begin
              pix_reg  <= '0;
              pass_reg <= pass_reg + 8'd1;
              if (last_pass) state_reg <= ST_FLUSH;
            end else begin
              pix_reg <= pix_reg + 1'b1;
            end
          end
        end
        ST_FLUSH: begin
          if (fifo_empty) state_reg <= ST_DONE;
        end
        default: begin
          state_reg <= ST_IDLE;
        end
      endcase
    end
  end

  sync_fifo #(
    .WIDTH (DATA_WIDTH),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (push),
    .push_data (push_data),
    .pop       (out_ready),
    .head      (fifo_head),
    .full      (fifo_full),
    .empty     (fifo_empty)
  );

  assign out_valid = !fifo_empty;
  assign out_data  = fifo_head;
  assign busy      = (state_reg == ST_RUN) || (state_reg == ST_FLUSH);
  assign done      = (state_reg == ST_DONE);
  assign err_cfg   = err_cfg_reg;

endmodule
